branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Consumes the 3-bit ALU status {V,N,Z} and applies it to control flow. Holds the
//  architectural status register and the program counter, evaluates branch
//  conditions (B/BEQ/BNE/BLT/BLE), and updates the PC as PC+1+sext(imm8).
//  Sits between the ALU status output, the CPU controller FSM and the instruction fetch address.
// PARAMETERS
//  PC_W   9   PC width in bits; must be >= 8; all PC arithmetic is modulo 2**PC_W
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     asynchronous, active-high reset
//  status_in   in   3     ALU status: [0]=Z, [1]=N, [2]=V
//  load_status in   1     capture status_in into status register this edge
//  br_valid    in   1     controller requests branch evaluation
//  br_ready    out  1     high only in IDLE; request accepted on edge with br_valid&br_ready
//  cond        in   3     000 B, 001 BEQ, 010 BNE, 011 BLT, 100 BLE, 101-111 illegal
//  imm8        in   8     signed two's-complement branch offset, sampled at accept
//  pc_inc      in   1     sequential fetch: PC <= PC+1 (honoured only in IDLE)
//  pc          out  PC_W  current program counter (registered)
//  status      out  3     registered status {V,N,Z}
//  taken       out  1     with done: branch was taken
//  done        out  1     one-cycle pulse: PC update committed
//  illegal     out  1     with done: cond was 101-111
// BEHAVIOUR
//  - Reset (async, any state): pc=0, status=000, state=IDLE, taken=0, done=0,
//    illegal=0; br_ready=1 once reset deasserts. In-flight request is discarded, no done.
//  - status register: load_status=1 -> status<=status_in; independent of FSM state.
//  - FSM IDLE->EVAL->UPDATE->IDLE. br_ready = (state==IDLE), combinational from state.
//  - IDLE: br_valid=1 -> latch cond, imm8; go EVAL. Else pc_inc=1 -> pc<=pc+1.
//    br_valid and pc_inc together: branch wins, pc_inc dropped, pc unchanged that edge.
//  - EVAL: compute take from *registered* status (so load_status on accept edge is
//    visible): B=1; BEQ=Z; BNE=~Z; BLT=N^V; BLE=(N^V)|Z; illegal: take=0, flag illegal.
//  - UPDATE: pc <= pc+1+sext(imm8) if take else pc+1; taken, illegal, done registered
//    to appear the cycle after UPDATE edge; return to IDLE.
//  - Latency: accept at edge k; new pc, done=1, taken, illegal visible after edge k+2;
//    br_ready high again after k+2 (back-to-back: next accept at edge k+3 earliest).
//  - done/taken/illegal are pulses: cleared on the following edge.
//  - sext: imm8[7] replicated to PC_W bits; sum truncated to PC_W bits (wrap, no flag).
//  - br_valid, pc_inc ignored outside IDLE; load_status honoured in every state.
// TESTING
//  1 BEQ taken: pc=0x010, load_status with status_in=001, accept cond=001 imm8=0x05
//    same edge -> after accept+2 edges pc=0x016, done=1, taken=1, illegal=0.
//  2 BNE not taken: status Z=1, pc=0x010, cond=010, imm8=0x05 -> pc=0x011, taken=0, done=1.
//  3 BLT back-branch: status=010 (N=1,V=0), pc=0x020, cond=011, imm8=0xFC -> pc=0x01D, taken=1.
//  4 Wrap + priority: pc=0x1FF, br_valid&pc_inc together, cond=000, imm8=0x01
//    -> pc stays 0x1FF at accept, then pc=0x001, taken=1; pc_inc had no effect.
//  5 Illegal cond=111, pc=0x040 -> pc=0x041, done=1, illegal=1, taken=0; BLE with status=001 -> taken=1.
//  6 Reset mid-op: assert reset during EVAL -> pc=0, status=000 immediately, no done
//    pulse after release, br_ready=1; subsequent pc_inc -> pc=0x001.

Source files
------------

// File: rtl/branch_cond_if.sv
// Handshake and data bundle between the CPU controller and the branch/condition unit.
// The controller side drives requests and status; the unit returns PC, status and completion flags.
interface branch_cond_if #(
    parameter int PC_W = 9
);
    logic [2:0]      status_in;
    logic            load_status;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      cond;
    logic [7:0]      imm8;
    logic            pc_inc;
    logic [PC_W-1:0] pc;
    logic [2:0]      status;
    logic            taken;
    logic            done;
    logic            illegal;

    modport master (
        output status_in, load_status, br_valid, cond, imm8, pc_inc,
        input  br_ready, pc, status, taken, done, illegal
    );

    modport slave (
        input  status_in, load_status, br_valid, cond, imm8, pc_inc,
        output br_ready, pc, status, taken, done, illegal
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: owns the {V,N,Z} status register and the program counter,
// resolves B/BEQ/BNE/BLT/BLE over a three-state IDLE->EVAL->UPDATE sequence.
module branch_cond_unit #(
    parameter int PC_W = 9
) (
    input  logic          clk,
    input  logic          reset,
    branch_cond_if.slave  bus
);

    if (PC_W < 8) begin : g_pc_w_check
        $error("branch_cond_unit: PC_W must be at least 8");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    state_t                 state;
    logic [2:0]             cond_q;
    logic signed [7:0]      imm_q;
    logic                   take_q;
    logic                   illegal_q;
    logic                   accept;

    // Status bit order is {V,N,Z}: [0]=Z, [1]=N, [2]=V.
    function automatic logic eval_take(input logic [2:0] c, input logic [2:0] s);
        logic z;
        logic n;
        logic v;
        logic r;
        z = s[0];
        n = s[1];
        v = s[2];
        case (c)
            COND_B:   r = 1'b1;
            COND_BEQ: r = z;
            COND_BNE: r = ~z;
            COND_BLT: r = n ^ v;
            COND_BLE: r = (n ^ v) | z;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic [2:0] c);
        return (c > COND_BLE);
    endfunction

    function automatic logic [PC_W-1:0] sext_imm(input logic signed [7:0] v);
        logic signed [PC_W-1:0] w;
        w = PC_W'(v);
        return w;
    endfunction

    // Sum wraps silently at PC_W bits.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] p,
                                                input logic t,
                                                input logic signed [7:0] imm);
        logic [PC_W-1:0] seq;
        seq = p + PC_W'(1);
        return t ? (seq + sext_imm(imm)) : seq;
    endfunction

    assign bus.br_ready = (state == IDLE);
    assign accept       = (state == IDLE) && bus.br_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.status <= 3'b000;
        end else if (bus.load_status) begin
            bus.status <= bus.status_in;
        end
    end

    // Request operands are captured on accept and only read in EVAL/UPDATE.
    always_ff @(posedge clk) begin
        if (accept) begin
            cond_q <= bus.cond;
            imm_q  <= bus.imm8;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bus.pc      <= '0;
            bus.taken   <= 1'b0;
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
            take_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            bus.taken   <= 1'b0;
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.br_valid) begin
                        state <= EVAL;
                    end else if (bus.pc_inc) begin
                        bus.pc <= bus.pc + PC_W'(1);
                    end
                end
                // Registered status is used so a load on the accept edge is seen here.
                EVAL: begin
                    take_q    <= eval_take(cond_q, bus.status);
                    illegal_q <= is_illegal(cond_q);
                    state     <= UPDATE;
                end
                UPDATE: begin
                    bus.pc      <= next_pc(bus.pc, take_q, imm_q);
                    bus.taken   <= take_q;
                    bus.illegal <= illegal_q;
                    bus.done    <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: expected branch results are queued at issue
// and popped when the unit signals done.
module tb_branch_cond_unit;

    localparam int PC_W = 9;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_cond_if #(.PC_W(PC_W)) bus();

    branch_cond_unit #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int              nvec = 0;
    int              nfail = 0;
    logic [PC_W-1:0] m_pc;
    logic [2:0]      m_status;
    exp_t            sb[$];

    function automatic logic m_take(input logic [2:0] c, input logic [2:0] s);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return s[0];
            3'd2:    return !s[0];
            3'd3:    return s[1] != s[2];
            3'd4:    return (s[1] != s[2]) || s[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [PC_W-1:0] m_next(input logic [PC_W-1:0] p, input logic t,
                                               input logic [7:0] imm);
        int o;
        o = t ? int'($signed(imm)) + 1 : 1;
        return PC_W'((int'(p) + o) & ((1 << PC_W) - 1));
    endfunction

    task automatic idle_inputs();
        bus.status_in   = 3'b000;
        bus.load_status = 1'b0;
        bus.br_valid    = 1'b0;
        bus.cond        = 3'b000;
        bus.imm8        = 8'h00;
        bus.pc_inc      = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pc     = '0;
        m_status = 3'b000;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic do_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pc_inc = 1'b1;
            @(negedge clk);
            m_pc = m_pc + PC_W'(1);
        end
        bus.pc_inc = 1'b0;
    endtask

    // Drives one request, queues its expected result, waits (bounded) for done.
    task automatic issue_branch(input logic [2:0] c, input logic [7:0] imm, input logic ld,
                                input logic [2:0] sin, input logic with_inc,
                                output logic [PC_W-1:0] pc_acc, output exp_t got,
                                output int lat);
        exp_t e;
        bus.br_valid    = 1'b1;
        bus.cond        = c;
        bus.imm8        = imm;
        bus.load_status = ld;
        bus.status_in   = sin;
        bus.pc_inc      = with_inc;
        if (ld) m_status = sin;
        e.taken   = m_take(c, m_status);
        e.illegal = (c > 3'd4);
        e.pc      = m_next(m_pc, e.taken, imm);
        m_pc      = e.pc;
        sb.push_back(e);
        @(negedge clk);
        pc_acc = bus.pc;
        idle_inputs();
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        got.pc      = bus.pc;
        got.taken   = bus.taken;
        got.illegal = bus.illegal;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (bus.pc !== '0) begin nfail++; $display("FAIL reset_pc: got %0h expected 0", bus.pc); end
        nvec++; if (bus.status !== 3'b000) begin nfail++; $display("FAIL reset_status: got %0b expected 000", bus.status); end
        nvec++; if ({bus.done, bus.taken, bus.illegal} !== 3'b000) begin nfail++;
            $display("FAIL reset_flags: got %0b expected 000", {bus.done, bus.taken, bus.illegal}); end
        reset = 1'b0;
        m_pc = '0;
        m_status = 3'b000;
        @(negedge clk);
        nvec++; if (bus.br_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %0b expected 1", bus.br_ready); end
    endtask

    task automatic test_beq_taken();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat;
        apply_reset();
        do_inc(16);
        nvec++; if (bus.pc !== 9'h010) begin nfail++; $display("FAIL inc_pc: got %0h expected 010", bus.pc); end
        issue_branch(3'b001, 8'h05, 1'b1, 3'b001, 1'b0, pa, g, lat);
        x = sb.pop_front();
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL beq_latency: got %0d expected 2", lat); end
        nvec++; if (g.pc !== x.pc) begin nfail++; $display("FAIL beq_pc: got %0h expected %0h", g.pc, x.pc); end
        nvec++; if ({g.taken, g.illegal} !== {x.taken, x.illegal}) begin nfail++;
            $display("FAIL beq_flags: got %0b expected %0b", {g.taken, g.illegal}, {x.taken, x.illegal}); end
        nvec++; if (bus.status !== 3'b001) begin nfail++; $display("FAIL beq_status: got %0b expected 001", bus.status); end
        @(negedge clk);
        nvec++; if ({bus.done, bus.taken} !== 2'b00) begin nfail++;
            $display("FAIL beq_pulse_clear: got %0b expected 00", {bus.done, bus.taken}); end
    endtask

    task automatic test_bne_not_taken();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat;
        apply_reset();
        do_inc(16);
        issue_branch(3'b010, 8'h05, 1'b1, 3'b001, 1'b0, pa, g, lat);
        x = sb.pop_front();
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL bne_latency: got %0d expected 2", lat); end
        nvec++; if (g.pc !== x.pc) begin nfail++; $display("FAIL bne_pc: got %0h expected %0h", g.pc, x.pc); end
        nvec++; if (g.taken !== x.taken) begin nfail++; $display("FAIL bne_taken: got %0b expected %0b", g.taken, x.taken); end
    endtask

    task automatic test_blt_back();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat;
        apply_reset();
        do_inc(32);
        issue_branch(3'b011, 8'hFC, 1'b1, 3'b010, 1'b0, pa, g, lat);
        x = sb.pop_front();
        nvec++; if (g.pc !== x.pc) begin nfail++; $display("FAIL blt_pc: got %0h expected %0h", g.pc, x.pc); end
        nvec++; if (g.taken !== x.taken) begin nfail++; $display("FAIL blt_taken: got %0b expected %0b", g.taken, x.taken); end
    endtask

    task automatic test_wrap_priority();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat;
        apply_reset();
        do_inc(511);
        issue_branch(3'b000, 8'h01, 1'b0, 3'b000, 1'b1, pa, g, lat);
        x = sb.pop_front();
        nvec++; if (pa !== 9'h1FF) begin nfail++; $display("FAIL wrap_pc_at_accept: got %0h expected 1ff", pa); end
        nvec++; if (g.pc !== x.pc) begin nfail++; $display("FAIL wrap_pc: got %0h expected %0h", g.pc, x.pc); end
        nvec++; if (g.taken !== 1'b1) begin nfail++; $display("FAIL wrap_taken: got %0b expected 1", g.taken); end
    endtask

    task automatic test_illegal_ble();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat;
        logic [2:0] cs [4] = '{3'b111, 3'b101, 3'b110, 3'b100};
        logic [2:0] ss [4] = '{3'b001, 3'b111, 3'b000, 3'b001};
        apply_reset();
        do_inc(64);
        for (int i = 0; i < 4; i++) begin
            issue_branch(cs[i], 8'h07, 1'b1, ss[i], 1'b0, pa, g, lat);
            x = sb.pop_front();
            nvec++; if (lat !== 2) begin nfail++; $display("FAIL ill_latency[%0d]: got %0d expected 2", i, lat); end
            nvec++; if (g !== x) begin nfail++;
                $display("FAIL ill_result[%0d]: got pc=%0h t=%0b i=%0b expected pc=%0h t=%0b i=%0b",
                         i, g.pc, g.taken, g.illegal, x.pc, x.taken, x.illegal); end
        end
    endtask

    task automatic test_cond_matrix();
        logic [PC_W-1:0] pa; exp_t g; exp_t x; int lat; logic [7:0] imm;
        logic [2:0] ss [6] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b100, 3'b011};
        for (int c = 0; c < 8; c++) begin
            for (int s = 0; s < 6; s++) begin
                imm = 8'($urandom_range(255));
                issue_branch(3'(c), imm, 1'b1, ss[s], 1'b0, pa, g, lat);
                x = sb.pop_front();
                nvec++; if (g !== x || lat !== 2) begin nfail++;
                    $display("FAIL cond%0d_st%0b: got pc=%0h t=%0b i=%0b lat=%0d expected pc=%0h t=%0b i=%0b lat=2",
                             c, ss[s], g.pc, g.taken, g.illegal, lat, x.pc, x.taken, x.illegal); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; exp_t x; int dones; logic [PC_W-1:0] start;
        start = m_pc;
        dones = 0;
        bus.br_valid = 1'b1;
        bus.cond     = 3'b000;
        bus.imm8     = 8'h02;
        bus.pc_inc   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.br_ready) begin
                e.taken = 1'b1; e.illegal = 1'b0; e.pc = m_next(m_pc, 1'b1, 8'h02);
                m_pc = e.pc;
                sb.push_back(e);
            end
            @(negedge clk);
            if (i == 0) begin
                nvec++; if (bus.br_ready !== 1'b0) begin nfail++; $display("FAIL b2b_ready_eval: got %0b expected 0", bus.br_ready); end
            end
            if (bus.done && sb.size() > 0) begin
                dones++;
                x = sb.pop_front();
                nvec++; if (bus.pc !== x.pc) begin nfail++; $display("FAIL b2b_pc[%0d]: got %0h expected %0h", dones, bus.pc, x.pc); end
            end
        end
        idle_inputs();
        nvec++; if (dones !== 2) begin nfail++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        nvec++; if (bus.pc !== PC_W'(start + PC_W'(6))) begin nfail++;
            $display("FAIL b2b_final_pc: got %0h expected %0h", bus.pc, PC_W'(start + PC_W'(6))); end
    endtask

    task automatic test_reset_mid_op();
        int stray;
        apply_reset();
        do_inc(5);
        bus.br_valid    = 1'b1;
        bus.cond        = 3'b000;
        bus.imm8        = 8'h03;
        bus.load_status = 1'b1;
        bus.status_in   = 3'b110;
        @(negedge clk);
        idle_inputs();
        nvec++; if (bus.status !== 3'b110) begin nfail++; $display("FAIL mid_status_loaded: got %0b expected 110", bus.status); end
        reset = 1'b1;
        #1;
        nvec++; if (bus.pc !== '0) begin nfail++; $display("FAIL mid_reset_pc: got %0h expected 0", bus.pc); end
        nvec++; if (bus.status !== 3'b000) begin nfail++; $display("FAIL mid_reset_status: got %0b expected 000", bus.status); end
        @(negedge clk);
        reset = 1'b0;
        m_pc = '0;
        m_status = 3'b000;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) stray++;
        end
        nvec++; if (stray !== 0) begin nfail++; $display("FAIL mid_no_done: got %0d done pulses expected 0", stray); end
        nvec++; if (bus.br_ready !== 1'b1) begin nfail++; $display("FAIL mid_ready: got %0b expected 1", bus.br_ready); end
        do_inc(1);
        nvec++; if (bus.pc !== 9'h001) begin nfail++; $display("FAIL mid_inc_pc: got %0h expected 001", bus.pc); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_blt_back();
        test_wrap_priority();
        test_illegal_ble();
        test_cond_matrix();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
